// File: rtl/program_sequencer.sv
// program_sequencer
//   Program counter for the 8b computer: increment with configurable wrap,
//   absolute jump, flag-conditional jump and a hardware return-address stack
//   for CALL/RET. One action is taken per rising edge. Priority order is
//   RET > CALL > J > JR > (JC & cond) > CE > hold. JR is present only when
//   REL_JUMP_EN is defined.
//
//   Optional feature macro: REL_JUMP_EN
//     Adds input JR. JR adds bus to PC, treating bus as a two's-complement
//     offset. The result is truncated to PC_WIDTH bits, and no MAX_ADDR wrap
//     is applied.
//
//   Parameters
//     PC_WIDTH     width of PC, bus and stack entries
//     MAX_ADDR     highest address reached by CE; a CE at or above it wraps to 0
//     STACK_DEPTH  number of return-address entries (>= 1)
//
//   Ports
//     clk          system clock, rising edge
//     rst          synchronous active-high reset
//     CE           increment PC
//     J            unconditional jump, PC <= bus
//     JC, cond     conditional jump, taken only when cond = 1
//     CALL         push PC, then PC <= bus
//     RET          pop top of stack into PC
//     bus          jump/call target (or relative offset for JR)
//     JR           relative jump (REL_JUMP_EN only)
//     PC           registered program counter
//     sp           number of valid stack entries
//     stack_full   sp == STACK_DEPTH
//     stack_empty  sp == 0
//     ovf          sticky: CALL attempted while full
//     unf          sticky: RET attempted while empty
module program_sequencer #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned MAX_ADDR    = 15,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CE,
  input  logic                J,
  input  logic                JC,
  input  logic                cond,
  input  logic                CALL,
  input  logic                RET,
  input  logic [PC_WIDTH-1:0] bus,
`ifdef REL_JUMP_EN
  input  logic                JR,
`endif
  output logic [PC_WIDTH-1:0] PC,
  output logic [SP_W-1:0]     sp,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                ovf,
  output logic                unf
);

  // Sized to the full sp range so sp indexes it without width adaptation;
  // entries at or above STACK_DEPTH are never written or read.
  logic [PC_WIDTH-1:0] stack [2**SP_W];

  logic [PC_WIDTH-1:0] pc_nxt;
  logic [SP_W-1:0]     sp_nxt;
  logic                ovf_nxt;
  logic                unf_nxt;
  logic                push;
  logic [PC_WIDTH-1:0] stack_top;

  // Unsigned increment with wrap: anything at or above MAX_ADDR returns to 0,
  // including a PC that was loaded beyond MAX_ADDR by a jump.
  function automatic logic [PC_WIDTH-1:0] inc_wrap(input logic [PC_WIDTH-1:0] v);
    return (v >= PC_WIDTH'(MAX_ADDR)) ? '0 : v + PC_WIDTH'(1);
  endfunction

`ifdef REL_JUMP_EN
  // Two's-complement add; the carry out is discarded so the result wraps
  // modulo 2**PC_WIDTH rather than at MAX_ADDR.
  function automatic logic [PC_WIDTH-1:0] rel_target(input logic [PC_WIDTH-1:0] base,
                                                     input logic [PC_WIDTH-1:0] off);
    logic signed [PC_WIDTH-1:0] soff;
    logic signed [PC_WIDTH-1:0] sbase;
    soff  = $signed(off);
    sbase = $signed(base);
    return $unsigned(sbase + soff);
  endfunction
`endif

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign stack_top   = stack[sp - SP_W'(1)];

  always_comb begin
    pc_nxt  = PC;
    sp_nxt  = sp;
    ovf_nxt = ovf;
    unf_nxt = unf;
    push    = 1'b0;
    // A rejected RET/CALL still owns the edge; lower strobes are ignored.
    if (RET) begin
      if (stack_empty) begin
        unf_nxt = 1'b1;
      end else begin
        pc_nxt = stack_top;
        sp_nxt = sp - SP_W'(1);
      end
    end else if (CALL) begin
      if (stack_full) begin
        ovf_nxt = 1'b1;
      end else begin
        push   = 1'b1;
        pc_nxt = bus;
        sp_nxt = sp + SP_W'(1);
      end
    end else if (J) begin
      pc_nxt = bus;
`ifdef REL_JUMP_EN
    end else if (JR) begin
      pc_nxt = rel_target(PC, bus);
`endif
    end else if (JC && cond) begin
      pc_nxt = bus;
    end else if (CE) begin
      pc_nxt = inc_wrap(PC);
    end
  end

  // Registered control state; all updates appear one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC  <= '0;
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      PC  <= pc_nxt;
      sp  <= sp_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end

  // Return-address storage: data only, never reset. The pushed value is the
  // current PC, which already points past the CALL.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      stack[sp] <= PC;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  localparam int unsigned PC_WIDTH    = 8;
  localparam int unsigned MAX_ADDR    = 15;
  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic                CE, J, JC, cond, CALL, RET;
  logic [PC_WIDTH-1:0] bus;
`ifdef REL_JUMP_EN
  logic                JR;
`endif
  logic [PC_WIDTH-1:0] PC;
  logic [SP_W-1:0]     sp;
  logic                stack_full, stack_empty, ovf, unf;

  int n_chk  = 0;
  int n_pass = 0;

  program_sequencer #(
    .PC_WIDTH   (PC_WIDTH),
    .MAX_ADDR   (MAX_ADDR),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .CE         (CE),
    .J          (J),
    .JC         (JC),
    .cond       (cond),
    .CALL       (CALL),
    .RET        (RET),
    .bus        (bus),
`ifdef REL_JUMP_EN
    .JR         (JR),
`endif
    .PC         (PC),
    .sp         (sp),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .ovf        (ovf),
    .unf        (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic chk_pc_sp(input string tag, input int exp_pc, input int exp_sp);
    check({tag, ".pc"}, 32'(PC), exp_pc);
    check({tag, ".sp"}, 32'(sp), exp_sp);
  endtask

  task automatic chk_flags(input string tag, input int e_full, input int e_empty,
                           input int e_ovf, input int e_unf);
    check({tag, ".full"},  32'(stack_full),  e_full);
    check({tag, ".empty"}, 32'(stack_empty), e_empty);
    check({tag, ".ovf"},   32'(ovf),         e_ovf);
    check({tag, ".unf"},   32'(unf),         e_unf);
  endtask

  // One rising edge, then settle away from it before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CE = 0; J = 0; JC = 0; cond = 0; CALL = 0; RET = 0; bus = '0;
`ifdef REL_JUMP_EN
    JR = 0;
`endif
  endtask

  int exp_pc;

  initial begin
    idle();
    rst = 1;
    cyc();
    chk_pc_sp("reset", 0, 0);
    chk_flags("reset", 0, 1, 0, 0);
    rst = 0;

    // Wrap at MAX_ADDR = 15
    CE = 1;
    exp_pc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      exp_pc = (exp_pc >= 15) ? 0 : exp_pc + 1;
      check("wrap.pc", 32'(PC), exp_pc);
      check("wrap.sp", 32'(sp), 0);
      check("wrap.ovf_unf", {30'd0, ovf, unf}, 0);
    end
    check("wrap.final", 32'(PC), 4);
    idle();

    // Jumps
    J = 1; bus = 9; cyc(); idle();
    chk_pc_sp("j9", 9, 0);
    JC = 1; cond = 0; CE = 1; bus = 3; cyc(); idle();
    chk_pc_sp("jc_not_taken", 10, 0);
    JC = 1; cond = 1; bus = 3; cyc(); idle();
    chk_pc_sp("jc_taken", 3, 0);
    J = 1; bus = 200; cyc(); idle();
    chk_pc_sp("j200", 200, 0);
    CE = 1; cyc(); idle();
    chk_pc_sp("ce_above_max", 0, 0);
    J = 1; JC = 1; cond = 1; CE = 1; bus = 6; cyc(); idle();
    chk_pc_sp("j_over_ce", 6, 0);

    // Nested calls
    J = 1; bus = 5; cyc(); idle();
    CALL = 1; bus = 12; cyc(); idle();
    chk_pc_sp("call12", 12, 1);
    CALL = 1; bus = 7; cyc(); idle();
    chk_pc_sp("call7", 7, 2);
    RET = 1; cyc(); idle();
    chk_pc_sp("ret1", 12, 1);
    RET = 1; cyc(); idle();
    chk_pc_sp("ret2", 5, 0);
    chk_flags("ret2", 0, 1, 0, 0);

    // Overflow / underflow; stack holds 5,20,21,22 after four calls
    for (int i = 0; i < 4; i++) begin
      CALL = 1; bus = PC_WIDTH'(20 + i); cyc(); idle();
    end
    chk_pc_sp("fill", 23, 4);
    chk_flags("fill", 1, 0, 0, 0);
    CALL = 1; J = 1; CE = 1; bus = 1; cyc(); idle();
    chk_pc_sp("call_full", 23, 4);
    chk_flags("call_full", 1, 0, 1, 0);
    RET = 1; cyc(); chk_pc_sp("pop1", 22, 3);
    cyc(); chk_pc_sp("pop2", 21, 2);
    cyc(); chk_pc_sp("pop3", 20, 1);
    cyc(); chk_pc_sp("pop4", 5, 0);
    CE = 1; cyc(); idle();
    chk_pc_sp("ret_empty", 5, 0);
    chk_flags("ret_empty", 0, 1, 1, 1);
    cyc(); cyc();
    chk_flags("sticky", 0, 1, 1, 1);

    // Priority
    J = 1; bus = 8; cyc(); idle();
    CALL = 1; bus = 50; cyc(); idle();
    chk_pc_sp("prio_setup", 50, 1);
    CE = 1; J = 1; CALL = 1; RET = 1; bus = 60; cyc(); idle();
    chk_pc_sp("prio_ret", 8, 0);
    CALL = 1; J = 1; bus = 4; cyc(); idle();
    chk_pc_sp("prio_call", 4, 1);
    RET = 1; cyc(); idle();
    chk_pc_sp("prio_ret_top", 8, 0);

    // Reset mid-sequence (ovf, unf still set from before)
    for (int i = 0; i < 3; i++) begin
      CALL = 1; bus = PC_WIDTH'(i + 1); cyc(); idle();
    end
    chk_pc_sp("pre_rst", 3, 3);
    check("pre_rst.ovf", 32'(ovf), 1);
    rst = 1; CALL = 1; bus = 9; cyc(); idle(); rst = 0;
    chk_pc_sp("mid_rst", 0, 0);
    chk_flags("mid_rst", 0, 1, 0, 0);

`ifdef REL_JUMP_EN
    J = 1; bus = 10; cyc(); idle();
    JR = 1; bus = 8'hFE; cyc(); idle();
    chk_pc_sp("jr_back", 8, 0);
    JR = 1; JC = 1; cond = 1; bus = 8'd250; cyc(); idle();
    chk_pc_sp("jr_trunc", 2, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
